sp_ram_arbiter: RTL and testbench

SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

---
 rtl/sp_ram_arbiter.sv | 131 +++++++++++++
 tb/tb_sp_ram_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_arbiter.sv
// Two-port arbiter in front of a single-port RAM with a fixed one-cycle response.
// Define SP_RAM_ARB_RR_EN for round-robin contention; default gives p1 fixed priority.
module sp_ram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    p0_req_i,
  output logic                    p0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
  input  logic                    p0_we_i,
  input  logic [DATA_WIDTH/8-1:0] p0_be_i,
  input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
  output logic                    p0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p0_rdata_o,
  input  logic                    p1_req_i,
  output logic                    p1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
  input  logic                    p1_we_i,
  input  logic [DATA_WIDTH/8-1:0] p1_be_i,
  input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
  output logic                    p1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p1_rdata_o,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic gnt0, gnt1;
  logic valid_q, valid_d;
  logic owner_q, owner_d;

`ifdef SP_RAM_ARB_RR_EN
  // prio_q = 1 means p1 is favoured on the next contention
  logic prio_q, prio_d;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst_i) begin
      if (p0_req_i && p1_req_i) begin
        gnt0 = ~prio_q;
        gnt1 = prio_q;
      end else begin
        gnt0 = p0_req_i;
        gnt1 = p1_req_i;
      end
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt0) begin
      prio_d = 1'b1;
    end else if (gnt1) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end
`else
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst_i) begin
      gnt1 = p1_req_i;
      gnt0 = p0_req_i & ~p1_req_i;
    end
  end
`endif

  // RAM request mux; idle cycles drive all request fields to zero
  always_comb begin
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    if (gnt1) begin
      ram_addr_o  = p1_addr_i;
      ram_wdata_o = p1_wdata_i;
      ram_we_o    = p1_we_i;
      ram_be_o    = BE_WIDTH'(p1_be_i);
    end else if (gnt0) begin
      ram_addr_o  = p0_addr_i;
      ram_wdata_o = p0_wdata_i;
      ram_we_o    = p0_we_i;
      ram_be_o    = BE_WIDTH'(p0_be_i);
    end
  end

  always_comb begin
    valid_d = gnt0 | gnt1;
    owner_d = owner_q;
    if (gnt0 | gnt1) begin
      owner_d = gnt1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
    end
  end

  assign p0_gnt_o = gnt0;
  assign p1_gnt_o = gnt1;
  assign ram_en_o = gnt0 | gnt1;

  // Reset in the response cycle kills the pending response as well
  assign p0_rvalid_o = valid_q & ~owner_q & ~rst_i;
  assign p1_rvalid_o = valid_q &  owner_q & ~rst_i;
  assign p0_rdata_o  = ram_rdata_i;
  assign p1_rdata_o  = ram_rdata_i;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed self-checking bench for sp_ram_arbiter with a behavioural single-port RAM.
// Expected arbitration follows SP_RAM_ARB_RR_EN when defined.
module tb_sp_ram_arbiter;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          p0_req_i, p1_req_i, p0_we_i, p1_we_i;
  logic [AW-1:0] p0_addr_i, p1_addr_i;
  logic [BW-1:0] p0_be_i, p1_be_i;
  logic [DW-1:0] p0_wdata_i, p1_wdata_i;
  logic          p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o;
  logic [DW-1:0] p0_rdata_o, p1_rdata_o;
  logic          ram_en_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_wdata_o, ram_rdata_i;
  logic [BW-1:0] ram_be_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_i(rst_i),
    .p0_req_i(p0_req_i), .p0_gnt_o(p0_gnt_o), .p0_addr_i(p0_addr_i), .p0_we_i(p0_we_i),
    .p0_be_i(p0_be_i), .p0_wdata_i(p0_wdata_i), .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
    .p1_req_i(p1_req_i), .p1_gnt_o(p1_gnt_o), .p1_addr_i(p1_addr_i), .p1_we_i(p1_we_i),
    .p1_be_i(p1_be_i), .p1_wdata_i(p1_wdata_i), .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
    .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_we_o(ram_we_o), .ram_be_o(ram_be_o), .ram_rdata_i(ram_rdata_i)
  );

  // Behavioural single-port RAM, word addressed, one-cycle read latency
  logic [DW-1:0] mem [0:(1<<(AW-2))-1];
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < int'(BW); b++)
          if (ram_be_o[b]) mem[ram_addr_o[AW-1:2]][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
      end else begin
        ram_rdata_i <= mem[ram_addr_o[AW-1:2]];
      end
    end
  end

  task automatic set_idle();
    rst_i = 1'b0;
    p0_req_i = 1'b0; p0_we_i = 1'b0; p0_addr_i = '0; p0_be_i = '0; p0_wdata_i = '0;
    p1_req_i = 1'b0; p1_we_i = 1'b0; p1_addr_i = '0; p1_be_i = '0; p1_wdata_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); set_idle(); rst_i = 1'b1;
    @(negedge clk); rst_i = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_idle(); rst_i = 1'b1; p0_req_i = 1'b1; p0_addr_i = AW'(16'h0040);
      #2;
      n_cmp++;
      if ({p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o, ram_en_o} !== 5'b0) begin
        n_err++; $display("FAIL reset_outputs: got %b expected 00000",
                          {p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o, ram_en_o});
      end
      n_cmp++;
      if (ram_addr_o !== '0 || ram_we_o !== 1'b0 || ram_be_o !== '0 || ram_wdata_o !== '0) begin
        n_err++; $display("FAIL reset_ram_bus: addr %h we %b be %b wdata %h expected zeros",
                          ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o);
      end
    end
    @(negedge clk); rst_i = 1'b0;
    #2;
    n_cmp++;
    if (p0_gnt_o !== 1'b1 || ram_en_o !== 1'b1 || ram_addr_o !== AW'(16'h0040)) begin
      n_err++; $display("FAIL post_reset_grant: gnt %b en %b addr %h expected 1 1 0040",
                        p0_gnt_o, ram_en_o, ram_addr_o);
    end
    @(negedge clk); set_idle();
    #2;
    n_cmp++;
    if (p0_rvalid_o !== 1'b1 || p1_rvalid_o !== 1'b0) begin
      n_err++; $display("FAIL post_reset_rvalid: p0 %b p1 %b expected 1 0", p0_rvalid_o, p1_rvalid_o);
    end
    n_cmp++;
    if (ram_en_o !== 1'b0 || ram_addr_o !== '0) begin
      n_err++; $display("FAIL idle_bus: en %b addr %h expected 0 0", ram_en_o, ram_addr_o);
    end
  endtask

  task automatic test_write_read();
    @(negedge clk); set_idle();
    p1_req_i = 1'b1; p1_we_i = 1'b1; p1_addr_i = AW'(16'h0010); p1_be_i = 4'b1111;
    p1_wdata_i = 32'hDEADBEEF;
    #2;
    n_cmp++;
    if (p1_gnt_o !== 1'b1 || ram_we_o !== 1'b1 || ram_wdata_o !== 32'hDEADBEEF || ram_be_o !== 4'b1111) begin
      n_err++; $display("FAIL p1_write_bus: gnt %b we %b wdata %h be %b expected 1 1 deadbeef 1111",
                        p1_gnt_o, ram_we_o, ram_wdata_o, ram_be_o);
    end
    @(negedge clk); set_idle();
    p0_req_i = 1'b1; p0_addr_i = AW'(16'h0010);
    #2;
    n_cmp++;
    if (p1_rvalid_o !== 1'b1 || p0_rvalid_o !== 1'b0 || p0_gnt_o !== 1'b1) begin
      n_err++; $display("FAIL write_ack: p1_rvalid %b p0_rvalid %b p0_gnt %b expected 1 0 1",
                        p1_rvalid_o, p0_rvalid_o, p0_gnt_o);
    end
    @(negedge clk); set_idle();
    #2;
    n_cmp++;
    if (p0_rvalid_o !== 1'b1 || p0_rdata_o !== 32'hDEADBEEF || p1_rvalid_o !== 1'b0) begin
      n_err++; $display("FAIL read_back: rvalid %b rdata %h expected 1 deadbeef", p0_rvalid_o, p0_rdata_o);
    end
  endtask

  task automatic test_byte_write();
    @(negedge clk); set_idle();
    p1_req_i = 1'b1; p1_we_i = 1'b1; p1_addr_i = AW'(16'h0020); p1_be_i = 4'b1111;
    p1_wdata_i = 32'h11223344;
    @(negedge clk);
    p1_be_i = 4'b0010; p1_wdata_i = 32'h0000AB00;
    #2;
    n_cmp++;
    if (p1_gnt_o !== 1'b1 || ram_be_o !== 4'b0010) begin
      n_err++; $display("FAIL byte_write_gnt: gnt %b be %b expected 1 0010", p1_gnt_o, ram_be_o);
    end
    @(negedge clk); set_idle();
    p0_req_i = 1'b1; p0_addr_i = AW'(16'h0020);
    @(negedge clk); set_idle();
    #2;
    n_cmp++;
    if (p0_rvalid_o !== 1'b1 || p0_rdata_o !== 32'h1122AB44) begin
      n_err++; $display("FAIL byte_merge: rvalid %b rdata %h expected 1 1122ab44", p0_rvalid_o, p0_rdata_o);
    end
  endtask

  task automatic test_contention();
    int exp_w;
    int prev_w;
    int ptr;
    do_reset();
    ptr = 0;
    prev_w = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); set_idle();
      p0_req_i = 1'b1; p0_addr_i = AW'(16'h0100);
      p1_req_i = 1'b1; p1_addr_i = AW'(16'h0200);
`ifdef SP_RAM_ARB_RR_EN
      exp_w = ptr;
      ptr = 1 - ptr;
`else
      exp_w = 1;
      ptr = 0;
`endif
      #2;
      n_cmp++;
      if (p0_gnt_o !== (exp_w == 0) || p1_gnt_o !== (exp_w == 1)) begin
        n_err++; $display("FAIL contend_grant[%0d]: p0 %b p1 %b expected winner p%0d",
                          i, p0_gnt_o, p1_gnt_o, exp_w);
      end
      n_cmp++;
      if (ram_addr_o !== (exp_w == 1 ? AW'(16'h0200) : AW'(16'h0100))) begin
        n_err++; $display("FAIL contend_addr[%0d]: got %h for winner p%0d", i, ram_addr_o, exp_w);
      end
      if (prev_w >= 0) begin
        n_cmp++;
        if (p0_rvalid_o !== (prev_w == 0) || p1_rvalid_o !== (prev_w == 1)) begin
          n_err++; $display("FAIL contend_rvalid[%0d]: p0 %b p1 %b expected owner p%0d",
                            i, p0_rvalid_o, p1_rvalid_o, prev_w);
        end
      end
      prev_w = exp_w;
    end
    // loser drops its request without ever being granted
    @(negedge clk); set_idle();
    #2;
    n_cmp++;
    if (ram_en_o !== 1'b0 || p0_gnt_o !== 1'b0 || p1_gnt_o !== 1'b0) begin
      n_err++; $display("FAIL dropped_req: en %b gnt %b%b expected 0 00", ram_en_o, p0_gnt_o, p1_gnt_o);
    end
    @(negedge clk);
    #2;
    n_cmp++;
    if (p0_rvalid_o !== 1'b0 || p1_rvalid_o !== 1'b0) begin
      n_err++; $display("FAIL dropped_rvalid: p0 %b p1 %b expected 0 0", p0_rvalid_o, p1_rvalid_o);
    end
  endtask

  task automatic test_reset_suppress();
    @(negedge clk); set_idle();
    p0_req_i = 1'b1; p0_addr_i = AW'(16'h0010);
    #2;
    n_cmp++;
    if (p0_gnt_o !== 1'b1) begin
      n_err++; $display("FAIL suppress_grant: got %b expected 1", p0_gnt_o);
    end
    @(negedge clk); set_idle(); rst_i = 1'b1;
    #2;
    n_cmp++;
    if (p0_rvalid_o !== 1'b0 || p1_rvalid_o !== 1'b0) begin
      n_err++; $display("FAIL suppress_n1: p0 %b p1 %b expected 0 0", p0_rvalid_o, p1_rvalid_o);
    end
    @(negedge clk); rst_i = 1'b0;
    #2;
    n_cmp++;
    if (p0_rvalid_o !== 1'b0 || p1_rvalid_o !== 1'b0) begin
      n_err++; $display("FAIL suppress_n2: p0 %b p1 %b expected 0 0", p0_rvalid_o, p1_rvalid_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] vals [0:2];
    vals[0] = 32'hA0A0_0001; vals[1] = 32'hB0B0_0002; vals[2] = 32'hC0C0_0003;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); set_idle();
      p1_req_i = 1'b1; p1_we_i = 1'b1; p1_be_i = 4'b1111;
      p1_addr_i = AW'(4 * i); p1_wdata_i = vals[i];
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); set_idle();
      if (i < 3) begin
        p0_req_i = 1'b1; p0_addr_i = AW'(4 * i);
      end
      #2;
      if (i < 3) begin
        n_cmp++;
        if (p0_gnt_o !== 1'b1 || ram_addr_o !== AW'(4 * i)) begin
          n_err++; $display("FAIL stream_grant[%0d]: gnt %b addr %h expected 1 %h",
                            i, p0_gnt_o, ram_addr_o, AW'(4 * i));
        end
      end
      if (i > 0) begin
        n_cmp++;
        if (p0_rvalid_o !== 1'b1 || p0_rdata_o !== vals[i-1]) begin
          n_err++; $display("FAIL stream_data[%0d]: rvalid %b rdata %h expected 1 %h",
                            i - 1, p0_rvalid_o, p0_rdata_o, vals[i-1]);
        end
      end
    end
  endtask

  initial begin
    set_idle();
    rst_i = 1'b1;
    test_reset();
    test_write_read();
    test_byte_write();
    test_contention();
    test_reset_suppress();
    test_back_to_back();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
